// File: rtl/ctrl_pkg.sv
// Shared types and widths for the run/done controller and the instruction decoder.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DUMP,
    DONE
  } state_t;

  localparam int CTRL_IW = 9;
  localparam int CTRL_DW = 8;
  localparam logic [CTRL_IW-1:0] CTRL_HALT_CODE = 9'b011111111;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_done_ctrl.sv
// Run/halt/dump/done sequencer: releases the core, catches HALT or a watchdog
// timeout, drains one cycle, streams the register file out, then raises Done.
module run_done_ctrl
  import ctrl_pkg::*;
#(
  parameter int             NREG       = 8,
  parameter int             DW         = CTRL_DW,
  parameter int             IW         = CTRL_IW,
  parameter logic [IW-1:0]  HALT_CODE  = CTRL_HALT_CODE,
  parameter int             CW         = 16,
  parameter int             MAX_CYCLES = 1000,
  localparam int            RW         = $clog2(NREG)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [IW-1:0] Instr,
  input  logic          InstrValid,
  output logic          Run,
  output logic [RW-1:0] RdAddr,
  input  logic [DW-1:0] RdData,
  output logic          DumpValid,
  input  logic          DumpReady,
  output logic [RW-1:0] DumpAddr,
  output logic [DW-1:0] DumpData,
  output logic [CW-1:0] CycleCount,
  output logic          Timeout,
  output logic          Done
);

  localparam logic [RW-1:0] LAST_ADDR = RW'(NREG - 1);
  localparam logic [CW-1:0] WD_LAST   = CW'(MAX_CYCLES - 1);
  localparam logic          WD_EN     = (MAX_CYCLES != 0);

  state_t        state_reg, state_next;
  logic [RW-1:0] rd_addr_reg, rd_addr_next;
  logic          timeout_reg, timeout_next;
  logic          halt_seen;
  logic          wd_fire;

  assign halt_seen = InstrValid && (Instr == HALT_CODE);
  assign wd_fire   = WD_EN && (CycleCount == WD_LAST);

  sat_counter #(
    .CW (CW)
  ) u_cycle_counter (
    .clk   (Clk),
    .rst   (Reset),
    .en    (state_reg == RUN),
    .clr   (state_reg == IDLE),
    .count (CycleCount)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg   <= IDLE;
      rd_addr_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rd_addr_reg <= rd_addr_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rd_addr_next = rd_addr_reg;
    timeout_next = timeout_reg;
    unique case (state_reg)
      IDLE: state_next = RUN;
      RUN: begin
        // A halt on the watchdog's last cycle is a clean finish, not a timeout.
        if (halt_seen) begin
          state_next = DRAIN;
        end else if (wd_fire) begin
          timeout_next = 1'b1;
          state_next   = DRAIN;
        end
      end
      DRAIN: begin
        state_next   = DUMP;
        rd_addr_next = '0;
      end
      DUMP: begin
        if (DumpReady) begin
          if (rd_addr_reg == LAST_ADDR) begin
            state_next = DONE;
          end else begin
            rd_addr_next = rd_addr_reg + 1'b1;
          end
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // The RF is frozen while Run is low, so the beat needs no holding register.
  assign Run       = (state_reg == RUN);
  assign DumpValid = (state_reg == DUMP);
  assign Done      = (state_reg == DONE);
  assign Timeout   = timeout_reg;
  assign RdAddr    = rd_addr_reg;
  assign DumpAddr  = rd_addr_reg;
  assign DumpData  = RdData;

endmodule

// File: tb/tb_run_done_ctrl.sv
// Directed bench for run_done_ctrl: halt, backpressure, watchdog, halt/watchdog
// tie, reset mid-dump and invalid-fetch halt codes.
module tb_run_done_ctrl;

  localparam int NREG = 8;
  localparam int DW   = 8;
  localparam int IW   = 9;
  localparam int CW   = 16;
  localparam int RW   = 3;
  localparam logic [IW-1:0] HALT = 9'b011111111;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic [IW-1:0] Instr = '0;
  logic          InstrValid = 1'b0;
  logic          Run;
  logic [RW-1:0] RdAddr;
  logic [DW-1:0] RdData;
  logic          DumpValid;
  logic          DumpReady = 1'b0;
  logic [RW-1:0] DumpAddr;
  logic [DW-1:0] DumpData;
  logic [CW-1:0] CycleCount;
  logic          Timeout;
  logic          Done;

  logic [DW-1:0] rf [NREG];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;
  assign RdData = rf[RdAddr];

  run_done_ctrl #(
    .NREG(NREG), .DW(DW), .IW(IW), .HALT_CODE(HALT), .CW(CW), .MAX_CYCLES(20)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .InstrValid(InstrValid), .Run(Run),
    .RdAddr(RdAddr), .RdData(RdData), .DumpValid(DumpValid), .DumpReady(DumpReady),
    .DumpAddr(DumpAddr), .DumpData(DumpData), .CycleCount(CycleCount),
    .Timeout(Timeout), .Done(Done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_rf(input int base, input int step);
    for (int i = 0; i < NREG; i++) rf[i] = DW'(base + i * step);
  endtask

  // Reset, release, and land in the first RUN cycle.
  task automatic start_run(input string tag);
    Reset = 1'b1; InstrValid = 1'b0; Instr = '0; DumpReady = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    chk({tag, "_run_hi"}, 32'(Run), 32'd1);
    chk({tag, "_cnt0"}, 32'(CycleCount), 32'd0);
  endtask

  // Stream the dump; bp selects the 1,0,0,1 ready pattern. Checks every beat.
  task automatic do_dump(input string tag, input bit bp);
    int e;
    int cyc;
    bit rdy;
    e = 0;
    cyc = 0;
    while (e < NREG && cyc < 100) begin
      rdy = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      DumpReady = rdy;
      chk({tag, "_valid"}, 32'(DumpValid), 32'd1);
      chk({tag, "_addr"}, 32'(DumpAddr), 32'(e));
      chk({tag, "_data"}, 32'(DumpData), 32'(rf[e]));
      chk({tag, "_notdone"}, 32'(Done), 32'd0);
      tick();
      if (rdy) e++;
      cyc++;
    end
    DumpReady = 1'b0;
    chk({tag, "_beats"}, 32'(e), 32'(NREG));
    chk({tag, "_done"}, 32'(Done), 32'd1);
    chk({tag, "_valid_lo"}, 32'(DumpValid), 32'd0);
  endtask

  initial begin
    load_rf(0, 1);
    #1;
    chk("rst_run", 32'(Run), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_to", 32'(Timeout), 32'd0);
    chk("rst_dv", 32'(DumpValid), 32'd0);
    chk("rst_addr", 32'(RdAddr), 32'd0);
    chk("rst_cnt", 32'(CycleCount), 32'd0);

    // Halt on the 5th fetch, ready held high.
    start_run("t1");
    for (int f = 1; f <= 5; f++) begin
      InstrValid = 1'b1;
      Instr = (f < 5) ? IW'(9'h012 + f) : HALT;
      tick();
      if (f == 4) chk("t1_run_f4", 32'(Run), 32'd1);
    end
    InstrValid = 1'b0;
    chk("t1_run_lo", 32'(Run), 32'd0);
    chk("t1_cnt", 32'(CycleCount), 32'd5);
    chk("t1_drain_dv", 32'(DumpValid), 32'd0);
    tick();
    do_dump("t1", 1'b0);
    chk("t1_to", 32'(Timeout), 32'd0);
    chk("t1_cnt_hold", 32'(CycleCount), 32'd5);
    $display("[TB] t1 halt-on-5th run done, cycles=%0d", CycleCount);
    // Halt codes after DONE are ignored.
    InstrValid = 1'b1; Instr = HALT;
    tick(); tick();
    InstrValid = 1'b0;
    chk("t1_done_sticky", 32'(Done), 32'd1);
    chk("t1_run_stays_lo", 32'(Run), 32'd0);

    // Backpressure.
    load_rf(8'hA0, 3);
    start_run("t2");
    InstrValid = 1'b1; Instr = 9'h005;
    tick();
    Instr = HALT;
    tick();
    InstrValid = 1'b0;
    chk("t2_cnt", 32'(CycleCount), 32'd2);
    tick();
    do_dump("t2", 1'b1);
    $display("[TB] t2 backpressure dump done");

    // Watchdog with no halt.
    load_rf(8'h31, 7);
    start_run("t3");
    for (int i = 0; i < 19; i++) tick();
    chk("t3_run_19", 32'(Run), 32'd1);
    chk("t3_cnt_19", 32'(CycleCount), 32'd19);
    chk("t3_to_pre", 32'(Timeout), 32'd0);
    tick();
    chk("t3_run_lo", 32'(Run), 32'd0);
    chk("t3_to", 32'(Timeout), 32'd1);
    chk("t3_cnt", 32'(CycleCount), 32'd20);
    tick();
    do_dump("t3", 1'b0);
    chk("t3_to_hold", 32'(Timeout), 32'd1);
    $display("[TB] t3 watchdog run done, timeout=%0d", Timeout);

    // Halt on the watchdog's last cycle.
    start_run("t4");
    for (int i = 0; i < 19; i++) tick();
    InstrValid = 1'b1; Instr = HALT;
    tick();
    InstrValid = 1'b0;
    chk("t4_run_lo", 32'(Run), 32'd0);
    chk("t4_to", 32'(Timeout), 32'd0);
    tick();
    do_dump("t4", 1'b0);
    chk("t4_to_end", 32'(Timeout), 32'd0);
    $display("[TB] t4 halt/watchdog tie done, timeout=%0d", Timeout);

    // Reset mid-dump, after the beat at addr 3 transfers.
    load_rf(8'h10, 5);
    start_run("t5");
    InstrValid = 1'b1; Instr = HALT;
    tick();
    InstrValid = 1'b0;
    tick();
    DumpReady = 1'b1;
    for (int b = 0; b < 4; b++) tick();
    DumpReady = 1'b0;
    chk("t5_mid_addr", 32'(DumpAddr), 32'd4);
    Reset = 1'b1;
    #1;
    chk("t5_rst_done", 32'(Done), 32'd0);
    chk("t5_rst_dv", 32'(DumpValid), 32'd0);
    chk("t5_rst_cnt", 32'(CycleCount), 32'd0);
    chk("t5_rst_addr", 32'(RdAddr), 32'd0);
    start_run("t5b");
    for (int f = 0; f < 4; f++) begin
      InstrValid = 1'b1;
      Instr = (f < 3) ? IW'(9'h100 + f) : HALT;
      tick();
    end
    InstrValid = 1'b0;
    chk("t5b_cnt", 32'(CycleCount), 32'd4);
    tick();
    do_dump("t5b", 1'b0);
    $display("[TB] t5 reset mid-dump then fresh run done");

    // Halt code with InstrValid low is not a halt.
    start_run("t6");
    InstrValid = 1'b0; Instr = HALT;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_run_hi", 32'(Run), 32'd1);
    chk("t6_cnt3", 32'(CycleCount), 32'd3);
    InstrValid = 1'b1;
    tick();
    InstrValid = 1'b0;
    chk("t6_run_lo", 32'(Run), 32'd0);
    chk("t6_cnt4", 32'(CycleCount), 32'd4);
    tick();
    do_dump("t6", 1'b0);
    $display("[TB] t6 invalid-halt run done, cycles=%0d", CycleCount);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/run_done_ctrl.md
Name: run_done_ctrl

Overview:
- Core-side counterpart of the host Clk/Reset/Done handshake inside Top.
- Releases the core into execution after reset and detects the halt instruction (or a watchdog timeout).
- Drains the pipeline, then streams the register-file contents out over a valid/ready dump port, then raises Done.
- Sits beside the fetch stage and RF1; the host waits on Done and consumes the dump instead of peeking at the register array.

Parameters:
- NREG, 8, number of register-file entries dumped.
- DW, 8, register data width.
- IW, 9, instruction width.
- HALT_CODE, 9'b011111111, machine code that terminates the program.
- CW, 16, cycle-counter width.
- MAX_CYCLES, 1000, watchdog limit in RUN cycles; 0 disables the watchdog.
- RW (derived), $clog2(NREG), register address width.

Ports:
- Clk  in  1  core clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Instr  in  IW  instruction currently fetched.
- InstrValid  in  1  Instr is a real fetch this cycle.
- Run  out  1  core enable: PC advance and register writes are allowed.
- RdAddr  out  RW  register-file read address during dump.
- RdData  in  DW  combinational register-file read data for RdAddr.
- DumpValid  out  1  dump beat valid.
- DumpReady  in  1  host accepts the dump beat.
- DumpAddr  out  RW  index of the current beat.
- DumpData  out  DW  register value of the current beat.
- CycleCount  out  CW  RUN cycles elapsed, saturating.
- Timeout  out  1  sticky: watchdog fired.
- Done  out  1  sticky: program finished and dump complete.

Behaviour:
- Reset values (asynchronous, immediate): state IDLE; Run=0, Done=0, Timeout=0, DumpValid=0, RdAddr=0, CycleCount=0.
- IDLE: on the first rising edge with Reset low -> RUN. Run=1 from that edge.
- RUN:
  - Run=1; CycleCount increments every cycle, saturating at 2^CW-1.
  - InstrValid && Instr==HALT_CODE sampled at an edge -> DRAIN. Run=0 from that edge; the core treats HALT as a no-op.
  - Watchdog: MAX_CYCLES!=0 and CycleCount==MAX_CYCLES-1 at an edge without a halt -> Timeout<=1, DRAIN.
  - Halt and watchdog on the same edge: halt wins, Timeout stays 0.
  - InstrValid=0: no halt detection that cycle; counting continues.
- DRAIN: exactly one cycle, so the final writeback lands. Run=0, CycleCount frozen. -> DUMP with RdAddr=0.
- DUMP:
  - DumpValid=1, DumpAddr=RdAddr, DumpData=RdData (combinational pass-through).
  - Addr and data stay stable while DumpReady=0; the RF cannot change because Run=0.
  - Beat transfers on an edge with DumpValid && DumpReady.
  - Transfer with RdAddr==NREG-1 -> DONE, DumpValid=0 on that edge. Otherwise RdAddr increments.
  - A DumpReady held high gives one beat per cycle, NREG beats total, no gaps.
- DONE: Done=1 and stays high until Reset. Run=0, DumpValid=0, CycleCount and Timeout held. Further halt codes are ignored.
- Reset asserted in any state, including mid-dump: all outputs return to reset values at once. A new run starts after deassertion.
- Widths: RdAddr wraps never occurs, because the terminal test happens before the increment. CycleCount saturates and never wraps.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DUMP, DONE};
  - the HALT_CODE default constant;
  - the shared IW/DW widths, so the decoder and this block agree.
- One sub-module, sat_counter (parameter CW; inputs en, clr; output count, saturating), for CycleCount.
- The FSM and dump addressing stay in run_done_ctrl.

Test Plan:
- Halt on the 5th fetch (4 normal instructions, then 9'b011111111), DumpReady=1 -> Run low after 5 RUN cycles; CycleCount=5; 8 consecutive beats addr 0..7 matching preloaded RF {0,1,2,...,7}; Done=1 one edge after the beat with addr 7; Timeout=0.
- Backpressure: DumpReady toggled 1,0,0,1,... -> each beat's DumpAddr/DumpData held stable while Ready=0; exactly 8 transfers, no repeats or skips.
- Watchdog, MAX_CYCLES=20, no halt -> Run falls after CycleCount=19, Timeout=1, the dump still runs, Done=1.
- Halt sampled on the same edge the watchdog would fire (halt at cycle 19, MAX_CYCLES=20) -> Timeout=0, Done=1 after the dump.
- Reset pulsed mid-dump (after the beat with addr 3) -> immediately Done=0, DumpValid=0, CycleCount=0. After release, a full fresh run completes with 8 beats starting at addr 0.
- InstrValid=0 while Instr==HALT_CODE for 3 cycles, then a real halt -> only the valid halt stops Run; CycleCount includes the 3 ignored cycles.
